// File: rtl/stream_mux_rr.sv
// N-channel, WIDTH-bit valid/ready stream multiplexer with one registered
// output stage. mode=0 selects the channel given by sel; mode=1 arbitrates
// round-robin among valid channels, starting after the last granted channel.
module stream_mux_rr #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic              r_valid;
  logic [WIDTH-1:0]  r_data;
  logic [SELW-1:0]   r_chan;
  logic [SELW-1:0]   r_ptr;

  logic              w_load;
  logic              w_xfer;
  logic              w_found;
  logic [N-1:0]      w_grant;
  logic [SELW-1:0]   w_gidx;
  logic [WIDTH-1:0]  w_gdata;

  // Grant: fixed select (out-of-range sel matches nothing) or rotating
  // priority search beginning at r_ptr+1, wrapping from N-1 to 0.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    if (!mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          w_grant[i] = 1'b1;
          w_gidx     = SELW'(i);
        end
      end
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (!w_found && in_valid[i] && i == (32'(r_ptr) + k) % N) begin
            w_grant[i] = 1'b1;
            w_gidx     = SELW'(i);
            w_found    = 1'b1;
          end
        end
      end
    end
  end

  // Data of the granted channel (zero when nothing is granted).
  always_comb begin
    w_gdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_gdata = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready only toward the granted channel, only when the output can load.
  always_comb begin
    w_load   = !r_valid | out_ready;
    in_ready = (rst_n && w_load) ? w_grant : '0;
    w_xfer   = |(in_valid & in_ready);
  end

  // Output register and last-grant pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= SELW'(N - 1);
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_gdata;
      r_chan  <= w_gidx;
      r_ptr   <= w_gidx;
    end else if (out_ready && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: an N=4 instance for arbitration,
// backpressure and reset, plus an N=3 instance for out-of-range sel and wrap.
module tb_stream_mux_rr;

  typedef struct {
    logic [1:0]  chan;
    logic [15:0] data;
  } word_t;

  logic        clk;
  logic        rst_n;

  logic [63:0] a_data;
  logic [3:0]  a_valid;
  logic [3:0]  a_ready;
  logic        a_mode;
  logic [1:0]  a_sel;
  logic [15:0] a_odata;
  logic [1:0]  a_ochan;
  logic        a_ovalid;
  logic        a_oready;

  logic [47:0] b_data;
  logic [2:0]  b_valid;
  logic [2:0]  b_ready;
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [15:0] b_odata;
  logic [1:0]  b_ochan;
  logic        b_ovalid;
  logic        b_oready;

  int unsigned n_pass;
  int unsigned n_total;
  word_t       sb[$];

  stream_mux_rr #(.WIDTH(16), .N(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .mode(a_mode), .sel(a_sel),
    .out_data(a_odata), .out_chan(a_ochan), .out_valid(a_ovalid),
    .out_ready(a_oready)
  );

  stream_mux_rr #(.WIDTH(16), .N(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .mode(b_mode), .sel(b_sel),
    .out_data(b_odata), .out_chan(b_ochan), .out_valid(b_ovalid),
    .out_ready(b_oready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [1:0] c, input logic [15:0] d);
    word_t w;
    w.chan = c;
    w.data = d;
    sb.push_back(w);
  endtask

  // Advance one cycle and compare the N=4 output against the scoreboard head.
  task automatic step_pop();
    word_t w;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(sb.size()), 64'd1);
    end else begin
      w = sb.pop_front();
      chk("out_valid", 64'(a_ovalid), 64'd1);
      chk("out_chan", 64'(a_ochan), 64'(w.chan));
      chk("out_data", 64'(a_odata), 64'(w.data));
    end
  endtask

  task automatic set_a_inc();
    for (int unsigned i = 0; i < 4; i++) a_data[i*16 +: 16] = 16'(16'h1000 + i);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    a_data = '0; a_valid = '0; a_mode = 1'b1; a_sel = '0; a_oready = 1'b1;
    b_data = '0; b_valid = '0; b_mode = 1'b0; b_sel = '0; b_oready = 1'b1;

    // Reset state, with valid inputs present
    a_valid = 4'hF;
    #12;
    chk("rst_valid", 64'(a_ovalid), 64'd0);
    chk("rst_data", 64'(a_odata), 64'd0);
    chk("rst_chan", 64'(a_ochan), 64'd0);
    chk("rst_ready", 64'(a_ready), 64'd0);
    a_valid = '0;
    rst_n = 1'b1;

    // Round-robin, all four valid: 0,1,2,3,0 with no bubble
    a_mode = 1'b1;
    set_a_inc();
    a_valid = 4'hF;
    #1;
    chk("rr_first_ready", 64'(a_ready), 64'h1);
    push(2'd0, 16'h1000); step_pop();
    push(2'd1, 16'h1001); step_pop();
    push(2'd2, 16'h1002); step_pop();
    push(2'd3, 16'h1003); step_pop();
    push(2'd0, 16'h1000); step_pop();

    // Fixed select, old two-way mux behaviour
    a_mode = 1'b0;
    a_sel  = 2'd0;
    a_data[15:0]  = 16'hAAAA;
    a_data[31:16] = 16'h5555;
    a_valid = 4'b0011;
    #1;
    chk("fix_ready0", 64'(a_ready), 64'h1);
    push(2'd0, 16'hAAAA); step_pop();
    a_sel = 2'd1;
    #1;
    chk("fix_ready1", 64'(a_ready), 64'h2);
    push(2'd1, 16'h5555); step_pop();

    // Round-robin with ch1 and ch3 only; last grant was ch1
    a_mode = 1'b1;
    set_a_inc();
    a_valid = 4'b1010;
    push(2'd3, 16'h1003); step_pop();
    push(2'd1, 16'h1001); step_pop();
    push(2'd3, 16'h1003); step_pop();
    push(2'd1, 16'h1001); step_pop();

    // Backpressure on a single active channel
    a_valid = 4'b0100;
    a_data[47:32] = 16'h2222;
    push(2'd2, 16'h2222); step_pop();
    a_oready = 1'b0;
    a_data[47:32] = 16'h2223;
    for (int unsigned c = 0; c < 3; c++) begin
      #1;
      chk("stall_ready", 64'(a_ready), 64'h0);
      @(posedge clk);
      #1;
      chk("stall_valid", 64'(a_ovalid), 64'd1);
      chk("stall_chan", 64'(a_ochan), 64'd2);
      chk("stall_data", 64'(a_odata), 64'h2222);
    end
    a_oready = 1'b1;
    #1;
    chk("unstall_ready", 64'(a_ready), 64'h4);
    push(2'd2, 16'h2223); step_pop();
    a_data[47:32] = 16'h2224;
    push(2'd2, 16'h2224); step_pop();
    a_valid = '0;
    @(posedge clk);
    #1;
    chk("drain_valid", 64'(a_ovalid), 64'd0);
    chk("drain_hold_data", 64'(a_odata), 64'h2224);
    chk("drain_hold_chan", 64'(a_ochan), 64'd2);

    // Mid-stream asynchronous reset; search restarts at channel 0
    set_a_inc();
    a_valid = 4'hF;
    push(2'd3, 16'h1003); step_pop();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(a_ovalid), 64'd0);
    chk("arst_data", 64'(a_odata), 64'd0);
    chk("arst_chan", 64'(a_ochan), 64'd0);
    chk("arst_ready", 64'(a_ready), 64'h0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(a_ready), 64'h1);
    push(2'd0, 16'h1000); step_pop();
    push(2'd1, 16'h1001); step_pop();
    a_valid = '0;
    @(posedge clk);
    #1;

    // N=3 instance: sel beyond channel count grants nothing
    for (int unsigned i = 0; i < 3; i++) b_data[i*16 +: 16] = 16'(16'h3000 + i);
    b_mode  = 1'b0;
    b_sel   = 2'd3;
    b_valid = 3'b111;
    #1;
    chk("n3_sel3_ready", 64'(b_ready), 64'h0);
    @(posedge clk);
    #1;
    chk("n3_sel3_valid", 64'(b_ovalid), 64'd0);
    b_sel = 2'd2;
    #1;
    chk("n3_sel2_ready", 64'(b_ready), 64'h4);
    @(posedge clk);
    #1;
    chk("n3_sel2_valid", 64'(b_ovalid), 64'd1);
    chk("n3_sel2_chan", 64'(b_ochan), 64'd2);
    chk("n3_sel2_data", 64'(b_odata), 64'h3002);
    b_valid = '0;
    @(posedge clk);
    #1;
    chk("n3_drain_valid", 64'(b_ovalid), 64'd0);

    // N=3 round-robin wrap from channel 2 to channel 0
    b_mode  = 1'b1;
    b_valid = 3'b101;
    #1;
    chk("n3_wrap_ready", 64'(b_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("n3_wrap_chan", 64'(b_ochan), 64'd0);
    chk("n3_wrap_data", 64'(b_odata), 64'h3000);
    chk("n3_next_ready", 64'(b_ready), 64'h4);
    @(posedge clk);
    #1;
    chk("n3_next_chan", 64'(b_ochan), 64'd2);
    chk("n3_next_data", 64'(b_odata), 64'h3002);
    b_valid = '0;

    chk("sb_leftover", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the 16-bit two-way mux: an N-channel, WIDTH-bit stream multiplexer.
- Each input and the output carries a valid/ready handshake; the selected word goes through one registered output stage.
- Two selection modes:
  - fixed-select mode, where an external sel picks the channel, as the old mux did;
  - round-robin mode, which gives fair arbitration among active channels.
- Sits between multiple producers (ALU results, memory reads, I/O) and a single consumer on the CPU datapath.

Parameters:
- WIDTH, 16, data width per channel in bits (>=1).
- N, 4, number of input channels (>=2; need not be a power of two).
- SELW, $clog2(N), width of channel index signals (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- mode  input  1  0 = fixed select by sel, 1 = round-robin.
- sel  input  SELW  channel index used when mode=0.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  SELW  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, last-grant pointer ptr=N-1. While in reset, in_ready=0.
- Reset asserted mid-operation discards any held word. After release, the first round-robin search starts at channel 0.
- Load enable: load = !out_valid | out_ready.
  - The output register accepts a new word when it is empty or is being drained in the same cycle.
  - This gives full throughput of 1 word/cycle.
- Grant (combinational, one-hot or zero):
  - mode=0: grant[sel]=1 iff in_valid[sel] and sel<N. If sel>=N, there is no grant.
  - mode=1: the first i with in_valid[i], searching ptr+1, ptr+2, ... modulo N. Wrap-around is from N-1 to 0. If no channel is valid, there is no grant.
- in_ready[i] = load & grant[i]. At most one in_ready bit is high per cycle. in_ready never depends on in_valid of other channels in mode=0.
- Transfer on channel g: in_valid[g] & in_ready[g]. At the next rising edge:
  - out_data <= channel g data;
  - out_chan <= g;
  - out_valid <= 1;
  - ptr <= g. ptr updates in both modes.
- No transfer but out_ready & out_valid: out_valid <= 0; out_data and out_chan hold their last values.
- Stall: while out_valid & !out_ready, out_data, out_chan and out_valid stay stable, and all in_ready are 0.
- Latency: 1 cycle from input transfer to out_valid.
- Mode or sel changes take effect on the next arbitration only. They never alter a held word.
- A single active channel in mode=1 is granted every cycle; there is no bubble.
- Data is passed unmodified; no arithmetic.

Test Plan:
1. Reset with rst_n=0 mid-stream (out_valid=1) -> out_valid drops to 0 immediately, without waiting for clk; out_data=0, out_chan=0, in_ready=0000.
2. mode=0, sel=0, ch0=16'hAAAA, ch1=16'h5555, both valid, out_ready=1:
   - next cycle out_data=AAAA, out_chan=0;
   - then set sel=1 -> out_data=5555, out_chan=1 one cycle later.
   This reproduces the old mux results, now registered.
3. mode=1, all four valid with data 0x1000+i, out_ready=1 -> out_chan sequence 0,1,2,3,0,... and out_valid held high every cycle.
4. mode=1, only ch1 and ch3 valid -> out_chan alternates 1,3,1,3, with wrap from 3 back to 1.
5. Backpressure:
   - out_ready=0 for 3 cycles with ch2 valid -> out_data/out_chan stable, in_ready=0000;
   - raising out_ready -> word drains that cycle and the next word loads at the same edge (no bubble).
6. Ready checks (N=3 instance):
   - mode=0, sel=2'd3 (>=N) -> in_ready=000, out_valid stays 0;
   - with no valid inputs -> out_valid deasserts one cycle after the last drain.
